// File: rtl/fifo_drain_ctrl.sv
// Read-side drain sequencer: pops fifo words, serialises them MSB byte first onto a
// valid/ready byte stream, frames them, and pads partial frames on a flush request.
module fifo_drain_ctrl #(
  parameter int                    DATA_WIDTH   = 16,
  parameter int                    READ_LATENCY = 1,
  parameter int                    FRAME_WORDS  = 512,
  parameter logic [DATA_WIDTH-1:0] PAD_WORD     = '1
) (
  input  logic                           rclk_i,
  input  logic                           rrst_n_i,
  input  logic                           enable_i,
  input  logic                           flush_i,
  input  logic [DATA_WIDTH-1:0]          fifo_rdata_i,
  input  logic                           fifo_rempty_i,
  output logic                           fifo_rinc_o,
  output logic [7:0]                     tx_data_o,
  output logic                           tx_valid_o,
  output logic                           tx_last_o,
  input  logic                           tx_ready_i,
  output logic [$clog2(FRAME_WORDS)-1:0] word_cnt_o,
  output logic                           busy_o
);

  localparam int BYTES   = DATA_WIDTH / 8;
  localparam int BIW     = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int CW      = $clog2(FRAME_WORDS);
  localparam int SET_CYC = (READ_LATENCY < 1) ? 1 : READ_LATENCY;

  localparam logic [1:0]     SET_LAST = 2'(SET_CYC - 1);
  localparam logic [BIW-1:0] LAST_B   = BIW'(BYTES - 1);
  localparam logic [CW-1:0]  LAST_WC  = CW'(FRAME_WORDS - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, SEND, PAD} state_t;

  state_t                  state_q;
  logic [1:0]              settle_q;
  logic [BIW-1:0]          byte_idx_q;
  logic [DATA_WIDTH-1:0]   hold_q;
  logic [CW-1:0]           word_cnt_q;
  logic                    pend_q;
  logic                    rinc_q;
  logic [7:0]              tx_data_q;
  logic                    tx_valid_q;
  logic                    tx_last_q;

  function automatic logic [7:0] sel_byte(input logic [DATA_WIDTH-1:0] w,
                                          input logic [BIW-1:0] idx);
    logic [DATA_WIDTH-1:0] sh;
    sh = w << (8 * idx);
    return sh[DATA_WIDTH-1 -: 8];
  endfunction

  function automatic logic is_last(input logic [BIW-1:0] idx, input logic [CW-1:0] wc);
    return (idx == LAST_B) && (wc == LAST_WC);
  endfunction

  always_ff @(posedge rclk_i or negedge rrst_n_i) begin
    if (!rrst_n_i) begin
      state_q    <= IDLE;
      settle_q   <= '0;
      byte_idx_q <= '0;
      hold_q     <= '0;
      word_cnt_q <= '0;
      pend_q     <= 1'b0;
      rinc_q     <= 1'b0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      tx_last_q  <= 1'b0;
    end else begin
      rinc_q <= 1'b0;
      // Clears below take precedence: a flush while already pending is a no-op.
      if (flush_i) pend_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (enable_i && !fifo_rempty_i) begin
            state_q  <= SETTLE;
            settle_q <= '0;
            rinc_q   <= (SET_CYC == 1);
          end else if (pend_q && fifo_rempty_i) begin
            if (word_cnt_q != '0) begin
              state_q    <= PAD;
              byte_idx_q <= '0;
              tx_valid_q <= 1'b1;
              tx_data_q  <= sel_byte(PAD_WORD, '0);
              tx_last_q  <= is_last('0, word_cnt_q);
            end else begin
              pend_q <= 1'b0;
            end
          end
        end
        SETTLE: begin
          if (settle_q == SET_LAST) begin
            state_q    <= SEND;
            hold_q     <= fifo_rdata_i;
            byte_idx_q <= '0;
            tx_valid_q <= 1'b1;
            tx_data_q  <= sel_byte(fifo_rdata_i, '0);
            tx_last_q  <= is_last('0, word_cnt_q);
          end else begin
            settle_q <= settle_q + 2'd1;
            rinc_q   <= (settle_q + 2'd1 == SET_LAST);
          end
        end
        SEND, PAD: begin
          if (!tx_valid_q) begin
            // Only reachable in PAD: gap cycle between padding words.
            byte_idx_q <= '0;
            tx_valid_q <= 1'b1;
            tx_data_q  <= sel_byte(PAD_WORD, '0);
            tx_last_q  <= is_last('0, word_cnt_q);
          end else if (tx_ready_i) begin
            if (byte_idx_q == LAST_B) begin
              tx_valid_q <= 1'b0;
              tx_last_q  <= 1'b0;
              byte_idx_q <= '0;
              word_cnt_q <= (word_cnt_q == LAST_WC) ? '0 : word_cnt_q + 1'b1;
              if (state_q == SEND) begin
                state_q <= IDLE;
              end else if (word_cnt_q == LAST_WC) begin
                state_q <= IDLE;
                pend_q  <= 1'b0;
              end
            end else begin
              byte_idx_q <= byte_idx_q + 1'b1;
              tx_data_q  <= sel_byte((state_q == PAD) ? PAD_WORD : hold_q,
                                     BIW'(byte_idx_q + 1'b1));
              tx_last_q  <= is_last(BIW'(byte_idx_q + 1'b1), word_cnt_q);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fifo_rinc_o = rinc_q;
  assign tx_data_o   = tx_data_q;
  assign tx_valid_o  = tx_valid_q;
  assign tx_last_o   = tx_last_q;
  assign word_cnt_o  = word_cnt_q;
  assign busy_o      = (state_q != IDLE) || pend_q;

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Directed bench for fifo_drain_ctrl with a 4-word frame and a simple fifo model.
module tb_fifo_drain_ctrl;
  localparam int DW = 16;
  localparam int FW = 4;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          flush = 1'b0;
  logic          tx_ready = 1'b0;
  logic [DW-1:0] fifo_rdata;
  logic          fifo_rempty;
  logic          fifo_rinc;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_last;
  logic [CW-1:0] word_cnt;
  logic          busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_drain_ctrl #(
    .DATA_WIDTH(DW), .READ_LATENCY(1), .FRAME_WORDS(FW), .PAD_WORD(16'hFFFF)
  ) dut (
    .rclk_i(clk), .rrst_n_i(rst_n), .enable_i(enable), .flush_i(flush),
    .fifo_rdata_i(fifo_rdata), .fifo_rempty_i(fifo_rempty), .fifo_rinc_o(fifo_rinc),
    .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_last_o(tx_last),
    .tx_ready_i(tx_ready), .word_cnt_o(word_cnt), .busy_o(busy)
  );

  // Fifo model: head word visible combinationally, empty updates the cycle after a pop.
  logic [DW-1:0] mem [0:31];
  int wr = 0;
  int rd = 0;
  assign fifo_rempty = (rd == wr);
  assign fifo_rdata  = mem[rd[4:0]];
  always @(posedge clk) if (fifo_rinc) rd <= rd + 1;

  logic [7:0] blog [0:255];
  logic       llog [0:255];
  int nb = 0;
  int nrinc = 0;
  always @(negedge clk) begin
    if (rst_n && tx_valid && tx_ready) begin
      blog[nb[7:0]] <= tx_data;
      llog[nb[7:0]] <= tx_last;
      nb <= nb + 1;
    end
    if (fifo_rinc) nrinc <= nrinc + 1;
  end

  task automatic push(input logic [DW-1:0] w);
    mem[wr[4:0]] = w;
    wr = wr + 1;
  endtask

  task automatic wait_bytes(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (nb >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; enable = 1'b0; flush = 1'b0; tx_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++; if (fifo_rinc !== 1'b0) begin errors++; $display("FAIL reset_rinc: got %b want 0", fifo_rinc); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", tx_valid); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", tx_data); end
    checks++; if (tx_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b want 0", tx_last); end
    checks++; if (word_cnt !== 2'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", word_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    do_reset();
  endtask

  task automatic test_single();
    int nb0, nr0;
    bit ok;
    nb0 = nb; nr0 = nrinc;
    @(posedge clk); #1;
    push(16'hA55A); tx_ready = 1'b1; enable = 1'b1;
    wait_bytes(nb0 + 2, 40, ok);
    repeat (3) @(negedge clk);
    checks++; if (!ok) begin errors++; $display("FAIL single_timeout: got %0d bytes want 2", nb - nb0); end
    checks++; if (blog[nb0] !== 8'hA5) begin errors++; $display("FAIL single_b0: got %h want a5", blog[nb0]); end
    checks++; if (blog[nb0+1] !== 8'h5A) begin errors++; $display("FAIL single_b1: got %h want 5a", blog[nb0+1]); end
    checks++; if (nrinc - nr0 !== 1) begin errors++; $display("FAIL single_rinc: got %0d want 1", nrinc - nr0); end
    checks++; if (word_cnt !== 2'd1) begin errors++; $display("FAIL single_cnt: got %0d want 1", word_cnt); end
    checks++; if (llog[nb0] !== 1'b0 || llog[nb0+1] !== 1'b0) begin errors++; $display("FAIL single_last: got %b%b want 00", llog[nb0], llog[nb0+1]); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %b want 0", busy); end
    enable = 1'b0;
  endtask

  task automatic test_frame();
    int nb0, nr0;
    bit ok;
    logic [7:0] eb;
    do_reset();
    nb0 = nb; nr0 = nrinc;
    @(posedge clk); #1;
    for (int i = 1; i <= 4; i++) push(16'(i));
    tx_ready = 1'b1; enable = 1'b1;
    wait_bytes(nb0 + 8, 100, ok);
    repeat (3) @(negedge clk);
    checks++; if (!ok) begin errors++; $display("FAIL frame_timeout: got %0d bytes want 8", nb - nb0); end
    for (int i = 0; i < 8; i++) begin
      eb = (i % 2 == 0) ? 8'h00 : 8'(i / 2 + 1);
      checks++; if (blog[nb0+i] !== eb) begin errors++; $display("FAIL frame_byte%0d: got %h want %h", i, blog[nb0+i], eb); end
      checks++; if (llog[nb0+i] !== (i == 7)) begin errors++; $display("FAIL frame_last%0d: got %b want %b", i, llog[nb0+i], (i == 7)); end
    end
    checks++; if (word_cnt !== 2'd0) begin errors++; $display("FAIL frame_cnt: got %0d want 0", word_cnt); end
    checks++; if (nrinc - nr0 !== 4) begin errors++; $display("FAIL frame_rinc: got %0d want 4", nrinc - nr0); end
    enable = 1'b0;
  endtask

  task automatic test_backpressure();
    int nb0, nr0;
    bit ok;
    do_reset();
    nb0 = nb; nr0 = nrinc;
    @(posedge clk); #1;
    push(16'hBEEF); tx_ready = 1'b0; enable = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx_valid) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL bp_valid_timeout: got %b want 1", tx_valid); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (tx_valid !== 1'b1 || tx_data !== 8'hBE) begin errors++; $display("FAIL bp_hold%0d: got %b/%h want 1/be", i, tx_valid, tx_data); end
      @(negedge clk);
    end
    checks++; if (nrinc - nr0 !== 1) begin errors++; $display("FAIL bp_rinc: got %0d want 1", nrinc - nr0); end
    @(posedge clk); #1 tx_ready = 1'b1;
    wait_bytes(nb0 + 2, 20, ok);
    repeat (2) @(negedge clk);
    checks++; if (!ok) begin errors++; $display("FAIL bp_timeout: got %0d bytes want 2", nb - nb0); end
    checks++; if (blog[nb0] !== 8'hBE || blog[nb0+1] !== 8'hEF) begin errors++; $display("FAIL bp_bytes: got %h %h want be ef", blog[nb0], blog[nb0+1]); end
    checks++; if (nrinc - nr0 !== 1) begin errors++; $display("FAIL bp_rinc_end: got %0d want 1", nrinc - nr0); end
    enable = 1'b0;
  endtask

  task automatic test_flush_pad();
    int nb0;
    bit ok;
    logic [7:0] eb;
    do_reset();
    nb0 = nb;
    @(posedge clk); #1;
    push(16'h1234); tx_ready = 1'b1; enable = 1'b1;
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    wait_bytes(nb0 + 8, 100, ok);
    repeat (4) @(negedge clk);
    checks++; if (!ok) begin errors++; $display("FAIL pad_timeout: got %0d bytes want 8", nb - nb0); end
    for (int i = 0; i < 8; i++) begin
      eb = (i == 0) ? 8'h12 : (i == 1) ? 8'h34 : 8'hFF;
      checks++; if (blog[nb0+i] !== eb) begin errors++; $display("FAIL pad_byte%0d: got %h want %h", i, blog[nb0+i], eb); end
      checks++; if (llog[nb0+i] !== (i == 7)) begin errors++; $display("FAIL pad_last%0d: got %b want %b", i, llog[nb0+i], (i == 7)); end
    end
    checks++; if (nb - nb0 !== 8) begin errors++; $display("FAIL pad_count: got %0d want 8", nb - nb0); end
    checks++; if (word_cnt !== 2'd0 || busy !== 1'b0) begin errors++; $display("FAIL pad_end: got cnt %0d busy %b want 0 0", word_cnt, busy); end
    // Flush on a frame boundary must send nothing.
    nb0 = nb;
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (nb - nb0 !== 0 || busy !== 1'b0) begin errors++; $display("FAIL empty_flush: got %0d bytes busy %b want 0 0", nb - nb0, busy); end
    enable = 1'b0;
  endtask

  task automatic test_empty_idle();
    int bad;
    do_reset();
    bad = 0;
    @(posedge clk); #1 enable = 1'b1; tx_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (fifo_rinc !== 1'b0 || tx_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL empty_idle: got %0d bad cycles want 0", bad); end
    enable = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    @(posedge clk); #1;
    push(16'h5678); tx_ready = 1'b0; enable = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx_valid) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL rmid_timeout: got %b want 1", tx_valid); end
    @(posedge clk); #1 tx_ready = 1'b1;
    @(posedge clk); #1 tx_ready = 1'b0; enable = 1'b0;
    @(negedge clk);
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h78 || busy !== 1'b1) begin errors++; $display("FAIL rmid_pre: got %b/%h/%b want 1/78/1", tx_valid, tx_data, busy); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (tx_valid !== 1'b0 || tx_data !== 8'h00 || tx_last !== 1'b0) begin errors++; $display("FAIL rmid_tx: got %b/%h/%b want 0/00/0", tx_valid, tx_data, tx_last); end
    checks++; if (busy !== 1'b0 || word_cnt !== 2'd0 || fifo_rinc !== 1'b0) begin errors++; $display("FAIL rmid_state: got %b/%0d/%b want 0/0/0", busy, word_cnt, fifo_rinc); end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0 || tx_valid !== 1'b0 || word_cnt !== 2'd0) begin errors++; $display("FAIL rmid_after: got %b/%b/%0d want 0/0/0", busy, tx_valid, word_cnt); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
    test_reset();
    test_single();
    test_frame();
    test_backpressure();
    test_flush_pad();
    test_empty_idle();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
